// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// optional first-word-fall-through read port and sticky overflow/underflow flags.
module fifo_sync_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, afull_q, aempty_q;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              rd_acc, wr_acc;

  // Acceptance, pointer advance and sticky error flag next-state.
  always_comb begin
    rd_acc   = rd_en & ~empty_q;
    wr_acc   = wr_en & (~full_q | rd_acc);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc);
    // Extra pointer bit makes the difference span 0..DEPTH without aliasing.
    count_d  = wr_ptr_d - rd_ptr_d;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en & ~wr_acc) ovf_d = 1'b1;
    if (rd_en & ~rd_acc) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == PTR_W'(DEPTH));
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= PTR_W'(AF_LEVEL));
      aempty_q <= (count_d <= PTR_W'(AE_LEVEL));
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem_q[rd_ptr_q[ADDR_W-1:0]];
      assign rd_valid = ~empty_q;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: standard-read instance and FWFT instance share stimulus.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, err_clr;
  logic [7:0] wr_data;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] s_count, f_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr)
  );

  fifo_sync_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 8'h00;
    cyc(); cyc();
    chk("rst_count", 32'(s_count), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_ae", 32'(s_ae), 32'd1);
    chk("rst_full", 32'(s_full), 32'd0);
    chk("rst_af", 32'(s_af), 32'd0);
    chk("rst_rd_valid", 32'(s_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(s_rd_data), 32'd0);
    chk("rst_ovf", 32'(s_ovf), 32'd0);
    chk("rst_unf", 32'(s_unf), 32'd0);
    chk("rst_fwft_valid", 32'(f_rd_valid), 32'd0);
    idle();

    // Fill 0x00..0x07, threshold flags track count.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      cyc();
      chk("fill_count", 32'(s_count), 32'(i + 1));
      chk("fill_af", 32'(s_af), (i + 1 >= 6) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(s_full), (i + 1 == 8) ? 32'd1 : 32'd0);
      chk("fill_ae", 32'(s_ae), (i + 1 <= 1) ? 32'd1 : 32'd0);
    end
    wr_data = 8'hFF;
    cyc();
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("ovf_count", 32'(s_count), 32'd8);
    idle();

    // Drain: each word appears one cycle after its rd_en.
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      cyc();
      chk("drain_valid", 32'(s_rd_valid), 32'd1);
      chk("drain_data", 32'(s_rd_data), 32'(i));
    end
    chk("drain_empty", 32'(s_empty), 32'd1);
    cyc();
    chk("unf_valid", 32'(s_rd_valid), 32'd0);
    chk("unf_set", 32'(s_unf), 32'd1);
    chk("unf_hold_data", 32'(s_rd_data), 32'h07);
    chk("ovf_sticky", 32'(s_ovf), 32'd1);
    rd_en = 1'b0; err_clr = 1'b1;
    cyc();
    chk("clr_ovf", 32'(s_ovf), 32'd0);
    chk("clr_unf", 32'(s_unf), 32'd0);
    idle();

    // Full with simultaneous write and read.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i);
      cyc();
    end
    chk("full_again", 32'(s_full), 32'd1);
    wr_data = 8'hA5; rd_en = 1'b1;
    cyc();
    chk("fullrw_count", 32'(s_count), 32'd8);
    chk("fullrw_data", 32'(s_rd_data), 32'h80);
    chk("fullrw_noovf", 32'(s_ovf), 32'd0);
    wr_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("fullrw_drain", 32'(s_rd_data), 32'(8'h80 + i));
    end
    cyc();
    chk("fullrw_last", 32'(s_rd_data), 32'hA5);
    chk("fullrw_empty", 32'(s_count), 32'd0);
    idle();

    // Empty with simultaneous write and read: read rejected.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
    cyc();
    chk("emptyrw_count", 32'(s_count), 32'd1);
    chk("emptyrw_unf", 32'(s_unf), 32'd1);
    chk("emptyrw_valid", 32'(s_rd_valid), 32'd0);
    wr_en = 1'b0;
    cyc();
    chk("emptyrw_data", 32'(s_rd_data), 32'h5A);
    chk("emptyrw_count0", 32'(s_count), 32'd0);
    rd_en = 1'b0; err_clr = 1'b1;
    cyc();
    idle();

    // Alternating write/read across pointer wrap.
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + k);
      cyc();
      wr_en = 1'b0; rd_en = 1'b1;
      chk("wrap_count1", 32'(s_count), 32'd1);
      cyc();
      rd_en = 1'b0;
      chk("wrap_data", 32'(s_rd_data), 32'(8'h10 + k));
      chk("wrap_count0", 32'(s_count), 32'd0);
    end

    // Reset mid-operation discards contents.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i);
      cyc();
    end
    chk("pre_rst_count", 32'(s_count), 32'd5);
    wr_en = 1'b0; rst = 1'b1;
    cyc();
    chk("mid_rst_count", 32'(s_count), 32'd0);
    chk("mid_rst_empty", 32'(s_empty), 32'd1);
    rst = 1'b0; wr_en = 1'b1; wr_data = 8'h77;
    cyc();
    wr_en = 1'b0; rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("post_rst_data", 32'(s_rd_data), 32'h77);
    chk("post_rst_valid", 32'(s_rd_valid), 32'd1);

    // FWFT: word visible without rd_en, rd_en pops it.
    rst = 1'b1;
    cyc();
    rst = 1'b0; wr_en = 1'b1; wr_data = 8'h3C;
    cyc();
    wr_en = 1'b0;
    chk("fwft_valid", 32'(f_rd_valid), 32'd1);
    chk("fwft_data", 32'(f_rd_data), 32'h3C);
    chk("fwft_count1", 32'(f_count), 32'd1);
    cyc();
    chk("fwft_hold", 32'(f_rd_data), 32'h3C);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("fwft_pop_valid", 32'(f_rd_valid), 32'd0);
    chk("fwft_pop_count", 32'(f_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
